mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory between the pipeline's instruction-fetch port and data port.
//   Sits between the processor's inst/data IO and a unified memory.
//   Grants one transaction at a time, with data priority bounded by an anti-starvation counter.
//   Sequences each transaction and returns a one-cycle valid pulse to the winning requester.
// PARAMETERS
//   ADDR_W        32  address width of all ports
//   DATA_W        32  data width; mask width is DATA_W/8
//   STARVE_LIMIT  4   max consecutive data grants while an inst request waits (>=1)
// PORTS
//   clk                input   1         rising-edge clock
//   reset              input   1         asynchronous, active-high reset
//   ip_inst_req        input   1         fetch request; held until op_inst_valid or abort
//   ip_inst_addr       input   ADDR_W    fetch address
//   ip_inst_abort      input   1         pipeline flush; drop pending/outstanding fetch
//   op_inst_valid      output  1         1-cycle pulse: op_inst_to_proc valid
//   op_inst_to_proc    output  DATA_W    fetched word
//   ip_data_rd         input   1         load request; held until op_data_valid
//   ip_data_wr         input   1         store request; held until op_data_valid (rd,wr exclusive)
//   ip_data_addr       input   ADDR_W    load/store address
//   ip_data_mask       input   DATA_W/8  store byte enables
//   ip_data_from_proc  input   DATA_W    store data
//   op_data_valid      output  1         1-cycle pulse: load data valid / store done
//   op_data_to_proc    output  DATA_W    load word (unmasked; alignment done by processor)
//   op_mem_addr        output  ADDR_W    memory address
//   op_mem_rd          output  1         memory read command
//   op_mem_wr          output  1         memory write command
//   op_mem_mask        output  DATA_W/8  memory byte enables
//   op_mem_wdata       output  DATA_W    memory write data
//   ip_mem_ready       input   1         memory accepts command this cycle
//   ip_mem_rvalid      input   1         read data valid (>=1 cycle after accept)
//   ip_mem_rdata       input   DATA_W    read data
// BEHAVIOUR
//   - Reset: state IDLE, streak counter 0, all op_* outputs 0 (addr/data/mask included).
//   - FSM states: IDLE, ISSUE, WAIT_RD, DONE.
//   - IDLE: arbitrate on registered decision.
//       data pending and (no inst pending or streak < STARVE_LIMIT) -> grant data;
//       otherwise inst pending -> grant inst (inst request ignored while ip_inst_abort=1).
//     Latch addr/cmd/mask/wdata into op_mem_* regs; go to ISSUE.
//   - ISSUE: hold op_mem_* stable until ip_mem_ready=1.
//       On accept: read -> WAIT_RD with op_mem_rd/wr cleared; write -> DONE.
//   - WAIT_RD: on ip_mem_rvalid, capture ip_mem_rdata into the owner's data reg; go to DONE.
//   - DONE: pulse owner's valid for exactly 1 cycle; return to IDLE.
//     New grant earliest the following cycle.
//     Min latency req->valid: 3 cycles (write, ready=1); 4 cycles (read, rvalid 1 cycle after accept).
//   - Streak: +1 on each data grant while ip_inst_req=1 (saturating at STARVE_LIMIT);
//     cleared on any inst grant or when ip_inst_req=0 in IDLE.
//   - Abort: ip_inst_abort=1 while owner=inst in ISSUE/WAIT_RD/DONE sets a sticky drop flag.
//     The memory transaction still completes (never cancel an accepted or presented command).
//     op_inst_valid is suppressed; the flag clears on return to IDLE.
//   - Data transactions are never aborted.
//   - Simultaneous inst+data request in IDLE with streak < LIMIT: data wins.
//   - ip_mem_rvalid outside WAIT_RD is ignored.
//   - Requests sampled only in IDLE; requester changes during a transaction are not observed.
//   - Reset mid-transaction: immediate return to IDLE, outputs 0; the in-flight response is discarded.
//   - ip_data_rd & ip_data_wr both 1: treated as a write (store); assertion flags it.
// STRUCTURE
//   - Shared package: FSM state encoding (IDLE/ISSUE/WAIT_RD/DONE), owner encoding (OWN_INST/OWN_DATA).
//   - One sub-module: mem_arb_grant (combinational priority + saturating streak counter),
//     instantiated once; FSM and datapath regs stay in the top.
// TESTING
//   - Inst-only read, mem ready=1, rvalid 1 cycle later, rdata=0x00000013 ->
//     op_inst_valid pulse 4 cycles after req, op_inst_to_proc=0x13, single pulse.
//   - Store addr=0x100, mask=4'b0100, wdata=0xAB<<16, ready delayed 3 cycles ->
//     op_mem_* held stable across the delay, op_data_valid 1 pulse after accept, no rvalid wait.
//   - Inst+data held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
//   - Abort during WAIT_RD of a fetch -> memory completes, no op_inst_valid.
//     A next fetch to addr 0x40 issued and returned normally.
//   - Assert reset in ISSUE with op_mem_rd=1 -> all outputs 0 same cycle (async), FSM in IDLE.
//     A late ip_mem_rvalid produces no valid pulse.
//   - Spurious ip_mem_rvalid in IDLE -> no valid pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Fixed data-over-inst priority with a saturating streak counter that
// forces an inst grant after STARVE_LIMIT consecutive data grants.
module mem_arb_grant
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in_idle,
   input  logic arb_en,
   input  logic inst_req,
   input  logic inst_abort,
   input  logic data_req,
   output logic grant_inst_c,
   output logic grant_data_c
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] streak_q;
   logic             inst_pend;
   logic             below_limit;

   assign inst_pend    = inst_req & ~inst_abort;
   assign below_limit  = (streak_q < CNT_W'(STARVE_LIMIT));
   assign grant_data_c = arb_en & data_req & (~inst_pend | below_limit);
   assign grant_inst_c = arb_en & inst_pend & ~grant_data_c;

   // Streak only grows while a fetch is actually waiting behind data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak_q <= '0;
      end else if (grant_inst_c || (in_idle && !inst_req)) begin
         streak_q <= '0;
      end else if (grant_data_c && inst_req && below_limit) begin
         streak_q <= streak_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port,
// one transaction at a time, with a one-cycle valid pulse to the winner.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ip_inst_req,
   input  logic [ADDR_W-1:0]   ip_inst_addr,
   input  logic                ip_inst_abort,
   output logic                op_inst_valid,
   output logic [DATA_W-1:0]   op_inst_to_proc,
   input  logic                ip_data_rd,
   input  logic                ip_data_wr,
   input  logic [ADDR_W-1:0]   ip_data_addr,
   input  logic [DATA_W/8-1:0] ip_data_mask,
   input  logic [DATA_W-1:0]   ip_data_from_proc,
   output logic                op_data_valid,
   output logic [DATA_W-1:0]   op_data_to_proc,
   output logic [ADDR_W-1:0]   op_mem_addr,
   output logic                op_mem_rd,
   output logic                op_mem_wr,
   output logic [DATA_W/8-1:0] op_mem_mask,
   output logic [DATA_W-1:0]   op_mem_wdata,
   input  logic                ip_mem_ready,
   input  logic                ip_mem_rvalid,
   input  logic [DATA_W-1:0]   ip_mem_rdata
);

   localparam int unsigned MASK_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   arb_owner_e          owner_q, owner_d;
   logic                drop_q, drop_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic                mem_rd_d, mem_wr_d;
   logic [MASK_W-1:0]   mem_mask_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic                inst_valid_d, data_valid_d;
   logic [DATA_W-1:0]   inst_rdata_d, data_rdata_d;
   logic                in_idle, arb_en, grant_inst_c, grant_data_c;

   // No new grant in the valid cycle: the finished requester still holds its request.
   assign in_idle = (state_q == ST_IDLE);
   assign arb_en  = in_idle & ~op_inst_valid & ~op_data_valid;

   mem_arb_grant #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clk          (clk),
      .reset        (reset),
      .in_idle      (in_idle),
      .arb_en       (arb_en),
      .inst_req     (ip_inst_req),
      .inst_abort   (ip_inst_abort),
      .data_req     (ip_data_rd | ip_data_wr),
      .grant_inst_c (grant_inst_c),
      .grant_data_c (grant_data_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         owner_q         <= OWN_INST;
         drop_q          <= 1'b0;
         op_mem_addr     <= '0;
         op_mem_rd       <= 1'b0;
         op_mem_wr       <= 1'b0;
         op_mem_mask     <= '0;
         op_mem_wdata    <= '0;
         op_inst_valid   <= 1'b0;
         op_data_valid   <= 1'b0;
         op_inst_to_proc <= '0;
         op_data_to_proc <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         drop_q          <= drop_d;
         op_mem_addr     <= mem_addr_d;
         op_mem_rd       <= mem_rd_d;
         op_mem_wr       <= mem_wr_d;
         op_mem_mask     <= mem_mask_d;
         op_mem_wdata    <= mem_wdata_d;
         op_inst_valid   <= inst_valid_d;
         op_data_valid   <= data_valid_d;
         op_inst_to_proc <= inst_rdata_d;
         op_data_to_proc <= data_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      drop_d       = drop_q;
      mem_addr_d   = op_mem_addr;
      mem_rd_d     = op_mem_rd;
      mem_wr_d     = op_mem_wr;
      mem_mask_d   = op_mem_mask;
      mem_wdata_d  = op_mem_wdata;
      inst_valid_d = 1'b0;
      data_valid_d = 1'b0;
      inst_rdata_d = op_inst_to_proc;
      data_rdata_d = op_data_to_proc;

      case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (grant_data_c) begin
               owner_d     = OWN_DATA;
               mem_addr_d  = ip_data_addr;
               mem_wr_d    = ip_data_wr;
               mem_rd_d    = ip_data_rd & ~ip_data_wr;
               mem_mask_d  = ip_data_wr ? ip_data_mask : '1;
               mem_wdata_d = ip_data_from_proc;
               state_d     = ST_ISSUE;
            end else if (grant_inst_c) begin
               owner_d     = OWN_INST;
               mem_addr_d  = ip_inst_addr;
               mem_wr_d    = 1'b0;
               mem_rd_d    = 1'b1;
               mem_mask_d  = '1;
               mem_wdata_d = '0;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (owner_q == OWN_INST && ip_inst_abort) drop_d = 1'b1;
            if (ip_mem_ready) begin
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               state_d  = op_mem_rd ? ST_WAIT_RD : ST_DONE;
            end
         end
         ST_WAIT_RD: begin
            if (owner_q == OWN_INST && ip_inst_abort) drop_d = 1'b1;
            if (ip_mem_rvalid) begin
               if (owner_q == OWN_INST) inst_rdata_d = ip_mem_rdata;
               else                     data_rdata_d = ip_mem_rdata;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            inst_valid_d = (owner_q == OWN_INST) & ~drop_q & ~ip_inst_abort;
            data_valid_d = (owner_q == OWN_DATA);
            drop_d       = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A simultaneous load and store request is executed as a store.
   a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(ip_data_rd && ip_data_wr));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small scripted memory responder.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        ip_inst_req;
   logic [31:0] ip_inst_addr;
   logic        ip_inst_abort;
   logic        op_inst_valid;
   logic [31:0] op_inst_to_proc;
   logic        ip_data_rd;
   logic        ip_data_wr;
   logic [31:0] ip_data_addr;
   logic [3:0]  ip_data_mask;
   logic [31:0] ip_data_from_proc;
   logic        op_data_valid;
   logic [31:0] op_data_to_proc;
   logic [31:0] op_mem_addr;
   logic        op_mem_rd;
   logic        op_mem_wr;
   logic [3:0]  op_mem_mask;
   logic [31:0] op_mem_wdata;
   logic        ip_mem_ready;
   logic        ip_mem_rvalid;
   logic [31:0] ip_mem_rdata;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          n_inst = 0;
   int          n_data = 0;
   int          inst_cyc = 0;
   int          data_cyc = 0;
   string       glog = "";
   logic        auto_mem = 1'b0;
   int          ready_delay = 0;
   int          wait_cnt = 0;
   logic [31:0] rd_word = 32'h0;

   mem_port_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .ip_inst_req       (ip_inst_req),
      .ip_inst_addr      (ip_inst_addr),
      .ip_inst_abort     (ip_inst_abort),
      .op_inst_valid     (op_inst_valid),
      .op_inst_to_proc   (op_inst_to_proc),
      .ip_data_rd        (ip_data_rd),
      .ip_data_wr        (ip_data_wr),
      .ip_data_addr      (ip_data_addr),
      .ip_data_mask      (ip_data_mask),
      .ip_data_from_proc (ip_data_from_proc),
      .op_data_valid     (op_data_valid),
      .op_data_to_proc   (op_data_to_proc),
      .op_mem_addr       (op_mem_addr),
      .op_mem_rd         (op_mem_rd),
      .op_mem_wr         (op_mem_wr),
      .op_mem_mask       (op_mem_mask),
      .op_mem_wdata      (op_mem_wdata),
      .ip_mem_ready      (ip_mem_ready),
      .ip_mem_rvalid     (ip_mem_rvalid),
      .ip_mem_rdata      (ip_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: observe valid pulses, then answer as the memory would.
   task automatic step();
      logic acc_rd;
      acc_rd = ip_mem_ready && op_mem_rd;
      @(posedge clk);
      #1;
      cyc++;
      if (op_inst_valid) begin n_inst++; inst_cyc = cyc; glog = {glog, "I"}; end
      if (op_data_valid) begin n_data++; data_cyc = cyc; glog = {glog, "D"}; end
      if (auto_mem) begin
         ip_mem_rvalid = acc_rd;
         ip_mem_rdata  = acc_rd ? rd_word : 32'h0;
         if (op_mem_rd || op_mem_wr) begin
            ip_mem_ready = (wait_cnt >= ready_delay);
            wait_cnt++;
         end else begin
            ip_mem_ready = 1'b0;
            wait_cnt     = 0;
         end
      end
   endtask

   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word,
                           output int lat, output logic [31:0] seen_addr);
      int c0, n0;
      rd_word = word; n0 = n_inst; c0 = cyc; lat = -1;
      ip_inst_req = 1'b1; ip_inst_addr = addr;
      step();
      seen_addr = op_mem_addr;
      for (int i = 0; i < 20 && n_inst == n0; i++) step();
      ip_inst_req = 1'b0;
      if (n_inst != n0) lat = inst_cyc - c0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if ({op_inst_valid, op_data_valid, op_mem_rd, op_mem_wr} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl got=%b want=0000",
                            {op_inst_valid, op_data_valid, op_mem_rd, op_mem_wr});
      end
      checks++;
      if ({op_mem_addr, op_mem_wdata, op_mem_mask} !== 68'h0) begin
         errors++; $display("FAIL reset_mem got addr=%h wdata=%h mask=%h want 0",
                            op_mem_addr, op_mem_wdata, op_mem_mask);
      end
      checks++;
      if ({op_inst_to_proc, op_data_to_proc} !== 64'h0) begin
         errors++; $display("FAIL reset_rdata got inst=%h data=%h want 0",
                            op_inst_to_proc, op_data_to_proc);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      auto_mem = 1'b1;
   endtask

   task automatic test_inst_fetch();
      int n0, lat;
      logic [31:0] a;
      ready_delay = 0; n0 = n_inst;
      do_fetch(32'h0000_0010, 32'h0000_0013, lat, a);
      checks++;
      if (a !== 32'h0000_0010) begin
         errors++; $display("FAIL fetch_addr got=%h want=00000010", a);
      end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL fetch_latency got=%0d want=4", lat); end
      checks++;
      if (op_inst_to_proc !== 32'h0000_0013) begin
         errors++; $display("FAIL fetch_data got=%h want=00000013", op_inst_to_proc);
      end
      repeat (4) step();
      checks++;
      if (n_inst != n0 + 1) begin
         errors++; $display("FAIL fetch_single_pulse got=%0d want=%0d", n_inst - n0, 1);
      end
   endtask

   task automatic test_store();
      int c0, n0, bad;
      ready_delay = 3; n0 = n_data; c0 = cyc; bad = 0;
      ip_data_wr = 1'b1; ip_data_addr = 32'h0000_0100;
      ip_data_mask = 4'b0100; ip_data_from_proc = 32'h00AB_0000;
      for (int i = 0; i < 4; i++) begin
         step();
         if (!(op_mem_wr === 1'b1 && op_mem_rd === 1'b0 && op_mem_addr === 32'h100 &&
               op_mem_mask === 4'b0100 && op_mem_wdata === 32'h00AB_0000)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL store_hold unstable_cycles=%0d want=0", bad); end
      step();
      checks++;
      if (op_mem_wr !== 1'b0 || n_data != n0) begin
         errors++; $display("FAIL store_accept got wr=%b pulses=%0d want wr=0 pulses=0",
                            op_mem_wr, n_data - n0);
      end
      step();
      ip_data_wr = 1'b0;
      checks++;
      if (n_data != n0 + 1 || data_cyc - c0 != 6) begin
         errors++; $display("FAIL store_valid got pulses=%0d at=%0d want 1 at 6",
                            n_data - n0, data_cyc - c0);
      end
      repeat (4) step();
      checks++;
      if (n_data != n0 + 1) begin
         errors++; $display("FAIL store_single_pulse got=%0d want=1", n_data - n0);
      end
      ready_delay = 0;
   endtask

   task automatic test_starvation();
      int c0, n0, first_d;
      c0 = cyc; n0 = n_data; first_d = -1; glog = "";
      rd_word = 32'hCAFE_0001;
      ip_inst_req = 1'b1; ip_inst_addr = 32'h0000_0200;
      ip_data_wr = 1'b1; ip_data_addr = 32'h0000_0300;
      ip_data_mask = 4'hF; ip_data_from_proc = 32'h1234_5678;
      for (int i = 0; i < 200 && glog.len() < 10; i++) begin
         step();
         if (first_d < 0 && n_data != n0) first_d = data_cyc - c0;
      end
      ip_inst_req = 1'b0; ip_data_wr = 1'b0;
      repeat (8) step();
      checks++;
      if (glog.substr(0, 9) != "DDDDIDDDDI") begin
         errors++; $display("FAIL starve_order got=%s want=DDDDIDDDDI", glog);
      end
      checks++;
      if (first_d != 3) begin errors++; $display("FAIL write_latency got=%0d want=3", first_d); end
      checks++;
      if (op_inst_to_proc !== 32'hCAFE_0001) begin
         errors++; $display("FAIL starve_fetch_data got=%h want=cafe0001", op_inst_to_proc);
      end
   endtask

   task automatic test_abort();
      int n0, lat;
      logic [31:0] a;
      n0 = n_inst; rd_word = 32'h0000_0A0A;
      ip_inst_req = 1'b1; ip_inst_addr = 32'h0000_0080;
      step();
      step();
      ip_inst_abort = 1'b1;
      step();
      ip_inst_abort = 1'b0; ip_inst_req = 1'b0;
      repeat (4) step();
      checks++;
      if (n_inst != n0) begin errors++; $display("FAIL abort_suppress got=%0d want=0", n_inst - n0); end
      checks++;
      if (op_inst_to_proc !== 32'h0000_0A0A) begin
         errors++; $display("FAIL abort_mem_done got=%h want=00000a0a", op_inst_to_proc);
      end
      do_fetch(32'h0000_0040, 32'h0000_0B0B, lat, a);
      checks++;
      if (a !== 32'h0000_0040 || lat != 4) begin
         errors++; $display("FAIL abort_next_fetch got addr=%h lat=%0d want 00000040 4", a, lat);
      end
      checks++;
      if (op_inst_to_proc !== 32'h0000_0B0B) begin
         errors++; $display("FAIL abort_next_data got=%h want=00000b0b", op_inst_to_proc);
      end
   endtask

   task automatic test_spurious_rvalid();
      int ni, nd, lat;
      logic [31:0] a, prev_i, prev_d;
      ni = n_inst; nd = n_data; prev_i = op_inst_to_proc; prev_d = op_data_to_proc;
      auto_mem = 1'b0;
      ip_mem_ready = 1'b0; ip_mem_rvalid = 1'b1; ip_mem_rdata = 32'hDEAD_BEEF;
      step(); step();
      ip_mem_rvalid = 1'b0;
      step(); step();
      checks++;
      if (n_inst != ni || n_data != nd) begin
         errors++; $display("FAIL spurious_pulse got inst=%0d data=%0d want 0 0",
                            n_inst - ni, n_data - nd);
      end
      checks++;
      if (op_inst_to_proc !== prev_i || op_data_to_proc !== prev_d || op_mem_rd !== 1'b0) begin
         errors++; $display("FAIL spurious_state got inst=%h data=%h rd=%b want %h %h 0",
                            op_inst_to_proc, op_data_to_proc, op_mem_rd, prev_i, prev_d);
      end
      auto_mem = 1'b1; wait_cnt = 0;
      do_fetch(32'h0000_0044, 32'h0000_0C0C, lat, a);
      checks++;
      if (lat != 4 || op_inst_to_proc !== 32'h0000_0C0C) begin
         errors++; $display("FAIL spurious_then_fetch got lat=%0d data=%h want 4 00000c0c",
                            lat, op_inst_to_proc);
      end
      repeat (3) step();
   endtask

   task automatic test_reset_mid_txn();
      int ni, lat;
      logic [31:0] a;
      ni = n_inst; ready_delay = 100;
      ip_inst_req = 1'b1; ip_inst_addr = 32'h0000_0048; rd_word = 32'h5555_5555;
      step();
      checks++;
      if (op_mem_rd !== 1'b1 || op_mem_addr !== 32'h48) begin
         errors++; $display("FAIL issue_before_reset got rd=%b addr=%h want 1 00000048",
                            op_mem_rd, op_mem_addr);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({op_mem_rd, op_mem_wr, op_inst_valid, op_data_valid} !== 4'b0000 ||
          {op_mem_addr, op_mem_mask, op_mem_wdata} !== 68'h0 ||
          {op_inst_to_proc, op_data_to_proc} !== 64'h0) begin
         errors++; $display("FAIL async_reset got rd=%b addr=%h mask=%h inst=%h want all 0",
                            op_mem_rd, op_mem_addr, op_mem_mask, op_inst_to_proc);
      end
      auto_mem = 1'b0; ip_inst_req = 1'b0; ip_mem_ready = 1'b0;
      step();
      reset = 1'b0;
      ip_mem_rvalid = 1'b1; ip_mem_rdata = 32'h5555_5555;
      step();
      ip_mem_rvalid = 1'b0;
      repeat (4) step();
      checks++;
      if (n_inst != ni || op_inst_to_proc !== 32'h0) begin
         errors++; $display("FAIL late_rvalid got pulses=%0d data=%h want 0 00000000",
                            n_inst - ni, op_inst_to_proc);
      end
      auto_mem = 1'b1; ready_delay = 0; wait_cnt = 0;
      do_fetch(32'h0000_004C, 32'h0000_0D0D, lat, a);
      checks++;
      if (a !== 32'h0000_004C || lat != 4) begin
         errors++; $display("FAIL post_reset_fetch got addr=%h lat=%0d want 0000004c 4", a, lat);
      end
   endtask

   initial begin
      reset = 1'b1;
      ip_inst_req = 1'b0; ip_inst_addr = 32'h0; ip_inst_abort = 1'b0;
      ip_data_rd = 1'b0; ip_data_wr = 1'b0; ip_data_addr = 32'h0;
      ip_data_mask = 4'h0; ip_data_from_proc = 32'h0;
      ip_mem_ready = 1'b0; ip_mem_rvalid = 1'b0; ip_mem_rdata = 32'h0;
      test_reset();
      test_inst_fetch();
      test_store();
      test_starvation();
      test_abort();
      test_spurious_rvalid();
      test_reset_mid_txn();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
